nios_pio_in_irq: RTL and testbench

Parametrised Avalon-MM slave input PIO with interrupt support, for push-buttons and switches on the Nios platforms. It synchronises WIDTH asynchronous inputs and captures programmable edges into sticky bits. Each bit has a per-bit interrupt mask, and a single level irq goes to the CPU. It is the next generation of the plain read-only button port and is register-compatible at offset 0.

---
 rtl/nios_pio_in_irq_pkg.sv | 13 +
 rtl/nios_pio_in_irq_debounce.sv | 34 +++
 rtl/nios_pio_in_irq.sv | 122 ++++++++++++
 tb/tb_nios_pio_in_irq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_in_irq_pkg.sv
// Shared constants for the Nios input PIO: the Avalon register offsets and
// the edge-capture mode encodings.
package nios_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_pio_in_irq_debounce.sv
// Single-bit stable-count filter. The output follows the input only after
// the input has disagreed with it for CYCLES consecutive clocks; any return
// to agreement restarts the count, so shorter glitches are swallowed.
module nios_pio_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  localparam logic [15:0] LAST = 16'(CYCLES - 1);

  logic [15:0] cnt;

  // Count consecutive disagreeing clocks; adopt d once the count completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d != q) begin
      if (cnt == LAST) begin
        q   <= d;
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/nios_pio_in_irq.sv
// Avalon-MM input PIO with edge capture and a masked level interrupt.
// Offset 0 stays read-compatible with the plain button port.
// Build option: define NIOS_PIO_DEBOUNCE_EN to insert a per-bit debouncer
// between the synchroniser and the data/edge logic.
module nios_pio_in_irq
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

`ifdef NIOS_PIO_DEBOUNCE_EN
  localparam int DEB_ADD = DEBOUNCE_CYCLES;
`else
  localparam int DEB_ADD = 0;
`endif
  // Clocks for a value present at reset release to reach prev_f; edges seen
  // before then are pipeline-fill artefacts, not real input activity.
  localparam int          ARM_CYCLES = SYNC_STAGES + 1 + DEB_ADD;
  localparam logic [17:0] ARM_MAX    = 18'(ARM_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s, f, prev_f, edge_det, w1c;
  logic [WIDTH-1:0] irq_mask, edge_capture;
  logic [17:0]      arm_cnt;
  logic             armed, wr;
  logic [31:0]      rd_nxt;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  // Input synchroniser shift chain; the last stage is the usable value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef NIOS_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    nios_pio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (s[i]),
      .q       (f[i])
    );
  end
`else
  assign f = s;
`endif

  // Previous filtered value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_f <= '0;
    else          prev_f <= f;
  end

  // Saturating arm counter gating capture after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                arm_cnt <= '0;
    else if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + 18'd1;
  end

  assign armed = (arm_cnt == ARM_MAX);

  // Per-bit edge detection in the configured mode.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = f & ~prev_f;
      EDGE_FALLING: edge_det = ~f & prev_f;
      default:      edge_det = f ^ prev_f;
    endcase
  end

  assign wr  = chipselect & ~write_n;
  assign w1c = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Sticky capture: clear by W1C, but a same-clock edge takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~w1c) | (armed ? edge_det : '0);
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             irq_mask <= '0;
    else if (wr && address == PIO_ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
  end

  // Read mux; unused bits and offsets return zero.
  always_comb begin
    rd_nxt = '0;
    case (address)
      PIO_ADDR_DATA:    rd_nxt[WIDTH-1:0] = f;
      PIO_ADDR_IRQMASK: rd_nxt[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: rd_nxt[WIDTH-1:0] = edge_capture;
      default:          rd_nxt = '0;
    endcase
  end

  // Registered read data, refreshed every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_nxt;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_pio_in_irq.sv
// Directed bench: three instances (rising, falling, any edge) share one bus
// and one input vector; expected values are hand-derived per step.
module tb_nios_pio_in_irq;
  import nios_pio_pkg::*;

  localparam int W  = 4;
  localparam int SS = 2;
`ifdef NIOS_PIO_DEBOUNCE_EN
  localparam int DEB = 16;
`else
  localparam int DEB = 0;
`endif
  // Posedges from an in_port change (made at a negedge) to edge capture.
  localparam int CAP = SS + 1 + DEB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_r, rd_f, rd_a;
  logic          irq_r, irq_f, irq_a;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  nios_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(EDGE_RISING), .DEBOUNCE_CYCLES(16)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_r), .irq(irq_r));
  nios_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(EDGE_FALLING), .DEBOUNCE_CYCLES(16)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_f), .irq(irq_f));
  nios_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; address = PIO_ADDR_DATA; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;
    cyc(3);
    check("rst_readdata", rd_r, 32'h0);
    check("rst_irq", {31'h0, irq_a}, 32'h0);

    // Release with inputs already high: no capture during pipeline fill.
    reset_n = 1'b1;
    cyc(6 + DEB);
    check("data_at_release", rd_r, 32'hF);
    rd(PIO_ADDR_EDGECAP);
    check("arm_rise", rd_r, 32'h0);
    check("arm_any", rd_a, 32'h0);
    check("arm_irq", {31'h0, irq_a}, 32'h0);

    // All bits fall: only falling/any capture.
    in_port = 4'h0;
    cyc(CAP + 1);
    rd(PIO_ADDR_EDGECAP);
    check("fall_rise_none", rd_r, 32'h0);
    check("fall_cap", rd_f, 32'hF);
    check("fall_any", rd_a, 32'hF);
    wr(PIO_ADDR_EDGECAP, 32'hF);
    rd(PIO_ADDR_EDGECAP);
    check("w1c_all", rd_f, 32'h0);
    wr(PIO_ADDR_IRQMASK, 32'h1);

    // Bit0 rises: irq exactly CAP posedges later.
    in_port = 4'h1;
    cyc(CAP - 1);
    check("irq_early", {31'h0, irq_r}, 32'h0);
    cyc(1);
    check("irq_on_time", {31'h0, irq_r}, 32'h1);
    check("irq_any", {31'h0, irq_a}, 32'h1);
    check("irq_fall_none", {31'h0, irq_f}, 32'h0);
    rd(PIO_ADDR_EDGECAP);
    check("cap_bit0", rd_r, 32'h1);
    wr(PIO_ADDR_EDGECAP, 32'h1);
    check("irq_w1c", {31'h0, irq_r}, 32'h0);

    // Bit2 edge lands in the same clock as its W1C: set wins.
    in_port = 4'h5;
    cyc(CAP - 1);
    wr(PIO_ADDR_EDGECAP, 32'h4);
    rd(PIO_ADDR_EDGECAP);
    check("set_wins", rd_r, 32'h4);
    check("set_wins_any", rd_a, 32'h4);
    check("irq_unmasked_bit", {31'h0, irq_r}, 32'h0);

    // Masking/unmasking a pending bit1.
    wr(PIO_ADDR_EDGECAP, 32'h4);
    wr(PIO_ADDR_IRQMASK, 32'h0);
    in_port = 4'h7;
    cyc(CAP + 1);
    rd(PIO_ADDR_EDGECAP);
    check("pend_bit1", rd_r, 32'h2);
    check("irq_masked", {31'h0, irq_r}, 32'h0);
    wr(PIO_ADDR_IRQMASK, 32'h2);
    check("irq_unmask", {31'h0, irq_r}, 32'h1);
    rd(PIO_ADDR_IRQMASK);
    check("mask_readback", rd_r, 32'h2);
    wr(PIO_ADDR_IRQMASK, 32'h0);
    check("irq_remask", {31'h0, irq_r}, 32'h0);
    rd(PIO_ADDR_EDGECAP);
    check("mask_keeps_cap", rd_r, 32'h2);
    wr(2'd1, 32'hF);
    rd(2'd1);
    check("unused_offset", rd_r, 32'h0);

    // Any-edge: bit3 up, clear, bit3 down.
    wr(PIO_ADDR_EDGECAP, 32'hF);
    in_port = 4'hF;
    cyc(CAP + 1);
    rd(PIO_ADDR_EDGECAP);
    check("any_first", rd_a, 32'h8);
    check("rise_bit3", rd_r, 32'h8);
    wr(PIO_ADDR_EDGECAP, 32'h8);
    rd(PIO_ADDR_EDGECAP);
    check("any_cleared", rd_a, 32'h0);
    in_port = 4'h7;
    cyc(CAP + 1);
    rd(PIO_ADDR_EDGECAP);
    check("any_second", rd_a, 32'h8);
    check("rise_no_fall", rd_r, 32'h0);
    check("fall_bit3", rd_f, 32'h8);

    // Reset mid-operation clears at once; arm period restarts.
    wr(PIO_ADDR_IRQMASK, 32'h8);
    check("irq_pre_reset", {31'h0, irq_a}, 32'h1);
    address = PIO_ADDR_EDGECAP;
    reset_n = 1'b0;
    #1;
    check("async_irq", {31'h0, irq_a}, 32'h0);
    check("async_readdata", rd_a, 32'h0);
    cyc(1);
    reset_n = 1'b1;
    cyc(6 + DEB);
    check("rearm_cap", rd_a, 32'h0);
    rd(PIO_ADDR_DATA);
    check("rearm_data", rd_a, 32'h7);

`ifdef NIOS_PIO_DEBOUNCE_EN
    // Short pulse on bit3 is filtered out entirely.
    in_port = 4'hF;
    cyc(10);
    in_port = 4'h7;
    cyc(40);
    check("deb_short_data", rd_r, 32'h7);
    rd(PIO_ADDR_EDGECAP);
    check("deb_short_cap", rd_a, 32'h0);
    // Long pulse: s changes after posedge 2, f after posedge 18, readdata after 19.
    address = PIO_ADDR_DATA;
    in_port = 4'hF;
    cyc(18);
    check("deb_long_before", rd_r, 32'h7);
    cyc(1);
    check("deb_long_after", rd_r, 32'hF);
    cyc(1);
    in_port = 4'h7;
    cyc(40);
    rd(PIO_ADDR_EDGECAP);
    check("deb_long_cap", rd_r, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
